// File: rtl/seqmon_pkg.sv
// seqmon_pkg: shared state encodings and sizing helpers for the pattern event monitor
package seqmon_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ARMED = 2'd1;
  localparam state_t ALARM = 2'd2;
  localparam int WCNT_W = 8;
  function automatic int win_w(input int len);
    return $clog2(len);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);
  always_ff @(posedge clk) begin
    if (rst || clr) value <= '0;
    else if (inc && value != '1) value <= value + 1'b1;
  end
endmodule

// File: rtl/pattern_event_monitor.sv
// pattern_event_monitor: rising-edge event counter with windowed sticky alarm
module pattern_event_monitor
  import seqmon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pattern_found,
  input  logic              alarm_ack,
  input  logic              clear,
  output logic [CNT_W-1:0]  total_count,
  output logic [WCNT_W-1:0] window_count,
  output logic              alarm,
  output logic [1:0]        state
);
  localparam int TW = win_w(WIN_LEN);
  localparam logic [TW-1:0] LAST = TW'(WIN_LEN - 1);
  localparam logic [WCNT_W-1:0] TH = WCNT_W'(THRESH);
  logic pf_q;
  logic [TW-1:0] timer;
  logic event_w;
  logic [TW-1:0] timer_nxt;
  logic [WCNT_W-1:0] wc_nxt;
  always_comb begin
    event_w   = pattern_found & ~pf_q;
    timer_nxt = timer + 1'b1;
    wc_nxt    = window_count + 1'b1;
  end
  sat_counter #(.W(CNT_W)) u_total (
    .clk(clk), .rst(rst), .inc(event_w), .clr(clear), .value(total_count)
  );
  // timer_nxt is the edge offset from the window's first event, so the window spans WIN_LEN edges
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_q         <= 1'b0;
      state        <= IDLE;
      timer        <= '0;
      window_count <= '0;
      alarm        <= 1'b0;
    end else begin
      pf_q <= pattern_found;
      if (state == IDLE) begin
        timer        <= '0;
        window_count <= event_w ? WCNT_W'(1) : '0;
        if (event_w) begin
          state <= (THRESH == 1) ? ALARM : ARMED;
          alarm <= (THRESH == 1);
        end
      end else if (state == ARMED) begin
        timer <= timer_nxt;
        if (event_w) window_count <= wc_nxt;
        if (event_w && wc_nxt == TH) begin
          state <= ALARM;
          alarm <= 1'b1;
        end else if (timer_nxt == LAST) begin
          state        <= IDLE;
          timer        <= '0;
          window_count <= '0;
        end
      end else if (state == ALARM) begin
        if (alarm_ack) begin
          state        <= IDLE;
          timer        <= '0;
          window_count <= '0;
          alarm        <= 1'b0;
        end
      end else begin
        state        <= IDLE;
        timer        <= '0;
        window_count <= '0;
        alarm        <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pattern_event_monitor.sv
// tb_pattern_event_monitor: directed plus random checks of two monitor instances against a window model
module tb_pattern_event_monitor;
  localparam int WIN_LEN = 16;
  localparam int THRESH  = 3;
  logic clk = 0, rst = 1, pattern_found = 0, alarm_ack = 0, clear = 0;
  logic [7:0] total_count, window_count, wc4;
  logic [3:0] total4;
  logic alarm, alarm4;
  logic [1:0] state, state4;
  int checks = 0, failures = 0;
  int cyc = 0, m_state = 0, m_start = 0, m_n = 0, m_tot8 = 0, m_tot4 = 0;
  bit m_pf = 0;

  always #5 clk = ~clk;

  pattern_event_monitor dut (
    .clk(clk), .rst(rst), .pattern_found(pattern_found), .alarm_ack(alarm_ack), .clear(clear),
    .total_count(total_count), .window_count(window_count), .alarm(alarm), .state(state)
  );
  pattern_event_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pattern_found(pattern_found), .alarm_ack(alarm_ack), .clear(clear),
    .total_count(total4), .window_count(wc4), .alarm(alarm4), .state(state4)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window model: an event counts if it lands within WIN_LEN edges of the window's first event
  task automatic model(input bit r, input bit p, input bit a, input bit c);
    bit ev;
    if (r) begin
      m_state = 0; m_n = 0; m_tot8 = 0; m_tot4 = 0; m_pf = 0;
      return;
    end
    ev = p && !m_pf;
    m_pf = p;
    if (c) begin m_tot8 = 0; m_tot4 = 0; end
    else if (ev) begin
      if (m_tot8 < 255) m_tot8++;
      if (m_tot4 < 15) m_tot4++;
    end
    case (m_state)
      0: if (ev) begin m_n = 1; m_start = cyc; m_state = (THRESH == 1) ? 2 : 1; end
      1: begin
        if (ev) m_n++;
        if (m_n == THRESH) m_state = 2;
        else if (cyc - m_start == WIN_LEN - 1) begin m_state = 0; m_n = 0; end
      end
      default: if (a) begin m_state = 0; m_n = 0; end
    endcase
  endtask

  task automatic step(input bit r, input bit p, input bit a, input bit c);
    rst = r; pattern_found = p; alarm_ack = a; clear = c;
    @(posedge clk);
    #1;
    cyc++;
    model(r, p, a, c);
    chk("state", state, m_state);
    chk("window_count", window_count, m_n);
    chk("alarm", alarm, m_state == 2);
    chk("total_count", total_count, m_tot8);
    chk("total_count_w4", total4, m_tot4);
    chk("state_w4", state4, m_state);
    chk("window_count_w4", wc4, m_n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic pulse();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    // reset held with pattern_found high; first post-reset edge counts one event
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("reset_total", total_count, 0);
    chk("reset_state", state, 0);
    step(0, 1, 0, 0);
    chk("post_reset_event", total_count, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("held_high_total", total_count, 1);
    chk("held_high_window", window_count, 1);
    // alarm path: pulses at 0, 4, 8, ack at 12
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); idle(3);
    step(0, 1, 0, 0); chk("alarm_path_wc2", window_count, 2); idle(3);
    step(0, 1, 0, 0);
    chk("alarm_path_alarm", alarm, 1);
    chk("alarm_path_total", total_count, 3);
    chk("alarm_path_state", state, 2);
    idle(3);
    step(0, 0, 1, 0);
    chk("ack_alarm", alarm, 0);
    chk("ack_state", state, 0);
    // expiry: pulses at 0 and 20
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); idle(14);
    chk("pre_expiry_state", state, 1);
    idle(1);
    chk("expiry_state", state, 0);
    chk("expiry_wc", window_count, 0);
    idle(4);
    step(0, 1, 0, 0);
    chk("new_window_wc", window_count, 1);
    chk("new_window_total", total_count, 2);
    chk("new_window_alarm", alarm, 0);
    // saturation and clear on the 4-bit instance
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      pulse();
      if (state == 2) step(0, 0, 1, 0);
    end
    chk("sat_total_w4", total4, 15);
    step(0, 0, 0, 1);
    chk("clear_alone", total4, 0);
    step(0, 1, 0, 1);
    chk("clear_vs_event", total4, 0);
    chk("clear_vs_event_w8", total_count, 0);
    // boundary: third pulse on the last window edge alarms instead of expiring
    step(1, 0, 0, 0);
    step(0, 1, 0, 0); idle(4);
    step(0, 1, 0, 0); idle(9);
    step(0, 1, 0, 0);
    chk("boundary_alarm", alarm, 1);
    idle(2);
    step(0, 1, 1, 0);
    chk("ack_event_total", total_count, 4);
    chk("ack_event_state", state, 0);
    chk("ack_event_wc", window_count, 0);
    step(0, 0, 0, 0);
    pulse(); pulse(); pulse();
    chk("rearm_alarm", alarm, 1);
    step(1, 0, 0, 0);
    chk("rst_in_alarm_alarm", alarm, 0);
    chk("rst_in_alarm_total", total_count, 0);
    chk("rst_in_alarm_state", state, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pattern_event_monitor.md
# pattern_event_monitor

Downstream consumer of the serial pattern detector's `pattern_found` output. Converts detector assertions into single events, keeps a saturating total event count, and raises a sticky alarm when `THRESH` events land within a `WIN_LEN`-cycle window. The alarm holds until software acknowledges it. Sits between the detector and the status/interrupt logic.

## Interface
Parameters:
- `CNT_W`, 8: width of the total event counter.
- `WIN_LEN`, 16: window length in cycles, 2..2^16.
- `THRESH`, 3: events per window that trigger the alarm, 1..255.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `pattern_found`, input, 1: detector output, level-sampled.
- `alarm_ack`, input, 1: alarm acknowledge, sampled each cycle.
- `clear`, input, 1: synchronous clear of `total_count` only.
- `total_count`, output, CNT_W: saturating count of events since reset or clear.
- `window_count`, output, 8: events counted in the current window.
- `alarm`, output, 1: sticky alarm flag.
- `state`, output, 2: FSM state, for debug.

## Operation
- Event is `pattern_found & ~pf_q`, where `pf_q` is a one-cycle delay of `pattern_found`. `pf_q` resets to 0. A held-high `pattern_found` gives exactly one event.
- `total_count`:
  - Increments by 1 on each event and saturates at 2^CNT_W-1.
  - `clear` wins over a same-cycle event; the result is 0.
  - Events are counted in every FSM state.
- FSM states: IDLE=0, ARMED=1, ALARM=2. Encoding 3 is unused and recovers to IDLE on the next edge.
- IDLE:
  - `window_count`=0, window timer=0.
  - On an event: `window_count`=1, timer=0. Go to ALARM if THRESH==1, else ARMED.
- ARMED:
  - Timer increments each cycle.
  - An event increments `window_count`. If the new value equals THRESH, go to ALARM.
  - If timer==WIN_LEN-1 and no alarm is triggered this cycle, go to IDLE and zero `window_count`.
  - An event on the last window cycle is counted. Alarm takes priority over expiry.
- ALARM:
  - `alarm`=1 and `window_count` is frozen at THRESH.
  - On `alarm_ack`: go to IDLE, `window_count`=0, `alarm`=0.
  - An event coinciding with the ack increments `total_count` but does not arm a new window.
- `alarm_ack` outside ALARM is ignored.
- `rst` on any cycle, including mid-window or mid-alarm, returns all state to its reset values at that edge.

## Timing
- Reset values: `total_count`=0, `window_count`=0, `alarm`=0, `state`=IDLE, `pf_q`=0, timer=0.
- Event latency: `pattern_found` rising in the cycle sampled at edge E makes `total_count` and `window_count` update at E, visible in the following cycle.
- Alarm latency: `alarm` rises at the same edge that samples the THRESH-th event; it is a registered output.
- Ack latency: `alarm` falls at the edge that samples `alarm_ack`=1.
- Window span:
  - The window covers WIN_LEN edges, counting from the edge that sampled the first event.
  - ARMED lasts at most WIN_LEN cycles.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package `seqmon_pkg`:
  - State typedef and its encodings (IDLE/ARMED/ALARM).
  - `WIN_W = $clog2(WIN_LEN)` helper function.
  - Window-count width constant (8).
- Sub-module `sat_counter`, parameterised by width:
  - Inputs: inc, clr, with clr priority.
  - Output: value, saturating.
  - Used for `total_count`.
- Top level contains the edge detect, FSM, window timer and window counter.

## Test plan
- Reset: hold `rst` for 2 cycles with `pattern_found`=1 -> all outputs 0 and `state`=0. The first edge after reset release counts one event (`pf_q` was 0).
- Alarm path (defaults): one-cycle pulses at cycles 0, 4, 8 -> `window_count` reads 1, 2, 3. `alarm`=1 after the cycle-8 edge, `total_count`=3, `state`=2. Ack at cycle 12 -> `alarm`=0, `state`=0, `window_count`=0.
- Expiry: pulses at cycles 0 and 20 -> after cycle 15 `state`=0 and `window_count`=0. Cycle 20 starts a new window with `window_count`=1. No alarm; `total_count`=2.
- Edge-only counting: `pattern_found` held high for 5 cycles -> `total_count`=1, `window_count`=1.
- Saturation and clear (CNT_W=4): 20 pulses -> `total_count`=15.
  - Then `clear` alone -> 0.
  - Then `clear` and an event in the same cycle -> 0.
- Boundary and reset (defaults): pulses at cycles 0, 5, 15 -> the third lands on timer=15 and gives `alarm`=1, not expiry.
  - An event coinciding with `alarm_ack` -> `total_count`+1 and `state`=IDLE.
  - `rst` asserted in ALARM -> all outputs 0 at that edge.
